// File: rtl/fifoc2mac.sv
// fifoc2mac: requests a MAC UDP transmit slot and streams a staged FIFO payload into it.
// Define FIFO2MAC_STAT_EN to add the stat_frames / stat_underrun counters.
module fifoc2mac #(
    parameter int          MAX_LEN     = 1472,
    parameter logic [7:0]  PAD_BYTE    = 8'h00,
    parameter logic [15:0] REQ_TIMEOUT = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fs,
    output logic        fd,
    input  logic [11:0] dat_tx_len,
    input  logic [7:0]  fifo_rxd,
    input  logic        fifo_empty,
    output logic        fifo_rxen,
    output logic        flag_udp_tx_req,
    input  logic        flag_udp_tx_prep,
    output logic        fs_udp_tx,
    input  logic        fd_udp_tx,
    output logic [15:0] udp_tx_len,
    input  logic        udp_txen,
    output logic [7:0]  udp_txd,
    output logic        err
`ifdef FIFO2MAC_STAT_EN
    ,
    output logic [15:0] stat_frames,
    output logic [15:0] stat_underrun
`endif
);

    localparam logic [11:0] MAX_LEN_W = 12'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_START,
        S_SEND,
        S_DRAIN,
        S_DONE
    } state_t;

    typedef struct packed {
        state_t      state;
        logic [11:0] len;
        logic [11:0] sent;
        logic [15:0] timer;
        logic        fd;
        logic        req;
        logic        fs_tx;
        logic [15:0] tx_len;
        logic        err;
        logic        rd_d;     // a payload byte arrives on fifo_rxd this cycle
    } ctx_t;

    ctx_t cur, nxt;
    logic have_byte;
    logic rd;
    logic underrun;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur <= '0;
        end else begin
            cur <= nxt;
        end
    end

    // NOTE: every signal is given a default at the top of the block; a path
    // that skipped an assignment would otherwise infer a latch.
    always_comb begin
        nxt       = cur;
        nxt.rd_d  = 1'b0;
        rd        = 1'b0;
        underrun  = 1'b0;
        have_byte = (cur.sent < cur.len) && !fifo_empty;

        case (cur.state)
            S_IDLE: begin
                nxt.sent  = '0;
                nxt.timer = '0;
                if (fs) begin
                    if (dat_tx_len > MAX_LEN_W) begin
                        nxt.len = MAX_LEN_W;
                        nxt.err = 1'b1;
                    end else begin
                        nxt.len = dat_tx_len;
                    end
                    if (dat_tx_len == 12'd0) begin
                        nxt.state = S_DONE;
                    end else begin
                        nxt.state = S_REQ;
                        nxt.req   = 1'b1;
                    end
                end
            end
            S_REQ: begin
                nxt.timer = cur.timer + 16'd1;
                if (flag_udp_tx_prep) begin
                    nxt.state = S_START;
                end else if (nxt.timer == REQ_TIMEOUT) begin
                    // Abandon the slot but still drain the staged payload.
                    nxt.err   = 1'b1;
                    nxt.req   = 1'b0;
                    nxt.state = S_DRAIN;
                end
            end
            S_START: begin
                nxt.fs_tx  = 1'b1;
                nxt.tx_len = {4'h0, cur.len};
                nxt.req    = 1'b0;
                nxt.state  = S_SEND;
            end
            S_SEND: begin
                if (udp_txen) begin
                    if (have_byte) begin
                        rd       = 1'b1;
                        nxt.sent = cur.sent + 12'd1;
                        nxt.rd_d = 1'b1;
                    end else if (cur.sent < cur.len) begin
                        underrun = 1'b1;
                    end
                end
                if (underrun) begin
                    nxt.err = 1'b1;
                end
                if (fd_udp_tx) begin
                    nxt.fs_tx = 1'b0;
                    nxt.state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (cur.sent >= cur.len) begin
                    nxt.state = S_DONE;
                end else if (have_byte) begin
                    rd       = 1'b1;
                    nxt.sent = cur.sent + 12'd1;
                end
            end
            S_DONE: begin
                if (!fs) begin
                    nxt.fd    = 1'b0;
                    nxt.state = S_IDLE;
                end else begin
                    nxt.fd = 1'b1;
                end
            end
            default: nxt.state = S_IDLE;
        endcase
    end

    assign fd              = cur.fd;
    assign fifo_rxen       = rd;
    assign flag_udp_tx_req = cur.req;
    assign fs_udp_tx       = cur.fs_tx;
    assign udp_tx_len      = cur.tx_len;
    assign err             = cur.err;
    // FIFO data is already one cycle late, so it is forwarded unregistered.
    assign udp_txd         = cur.rd_d ? fifo_rxd : PAD_BYTE;

`ifdef FIFO2MAC_STAT_EN
    logic enter_done;
    assign enter_done = (nxt.state == S_DONE) && (cur.state != S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_frames   <= '0;
            stat_underrun <= '0;
        end else begin
            if (enter_done) stat_frames <= stat_frames + 16'd1;
            if (underrun)   stat_underrun <= stat_underrun + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifoc2mac.sv
// Directed bench for fifoc2mac: a small behavioural FIFO feeds the DUT and the
// bench plays the MAC side by hand.
module tb_fifoc2mac;

    localparam logic [7:0] PAD = 8'hA5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fs;
    logic        fd;
    logic [11:0] dat_tx_len;
    logic [7:0]  fifo_rxd;
    logic        fifo_empty;
    logic        fifo_rxen;
    logic        flag_udp_tx_req;
    logic        flag_udp_tx_prep;
    logic        fs_udp_tx;
    logic        fd_udp_tx;
    logic [15:0] udp_tx_len;
    logic        udp_txen;
    logic [7:0]  udp_txd;
    logic        err;
`ifdef FIFO2MAC_STAT_EN
    logic [15:0] stat_frames;
    logic [15:0] stat_underrun;
`endif

    int n_pass = 0;
    int n_total = 0;

    fifoc2mac #(
        .MAX_LEN    (1472),
        .PAD_BYTE   (PAD),
        .REQ_TIMEOUT(16'd16)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fs              (fs),
        .fd              (fd),
        .dat_tx_len      (dat_tx_len),
        .fifo_rxd        (fifo_rxd),
        .fifo_empty      (fifo_empty),
        .fifo_rxen       (fifo_rxen),
        .flag_udp_tx_req (flag_udp_tx_req),
        .flag_udp_tx_prep(flag_udp_tx_prep),
        .fs_udp_tx       (fs_udp_tx),
        .fd_udp_tx       (fd_udp_tx),
        .udp_tx_len      (udp_tx_len),
        .udp_txen        (udp_txen),
        .udp_txd         (udp_txd),
        .err             (err)
`ifdef FIFO2MAC_STAT_EN
        ,
        .stat_frames     (stat_frames),
        .stat_underrun   (stat_underrun)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural FIFO: write port driven by the bench, read data valid one cycle after fifo_rxen.
    logic [7:0] mem [64];
    int         wp = 0;
    int         rp = 0;
    int         cnt = 0;
    int         rxen_cnt = 0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;

    always @(posedge clk) begin
        if (wr_en) begin
            mem[wp[5:0]] <= wr_data;
            wp <= wp + 1;
        end
        if (fifo_rxen) begin
            fifo_rxd <= mem[rp[5:0]];
            rp <= rp + 1;
            rxen_cnt <= rxen_cnt + 1;
        end
        cnt <= cnt + (wr_en ? 1 : 0) - (fifo_rxen ? 1 : 0);
    end

    assign fifo_empty = (cnt == 0);

    task automatic push(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_data = first + 8'(i);
            @(negedge clk);
        end
        wr_en = 1'b0;
    endtask

    // Drives fs with prep already high: IDLE -> REQ -> START -> SEND in three clocks.
    task automatic start_frame(input logic [11:0] len);
        dat_tx_len       = len;
        fs               = 1'b1;
        flag_udp_tx_prep = 1'b1;
        repeat (3) @(negedge clk);
        flag_udp_tx_prep = 1'b0;
    endtask

    task automatic wait_fd(input int limit);
        for (int i = 0; i < limit && !fd; i++) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n            = 1'b0;
        fs               = 1'b0;
        dat_tx_len       = '0;
        flag_udp_tx_prep = 1'b0;
        fd_udp_tx        = 1'b0;
        udp_txen         = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({fd, fifo_rxen, flag_udp_tx_req, fs_udp_tx, err} !== 5'b0)
            $display("FAIL reset_flags: got %b want 00000", {fd, fifo_rxen, flag_udp_tx_req, fs_udp_tx, err});
        else n_pass++;
        n_total++;
        if (udp_tx_len !== 16'h0000) $display("FAIL reset_tx_len: got %h want 0000", udp_tx_len);
        else n_pass++;
        n_total++;
        if (udp_txd !== PAD) $display("FAIL reset_txd: got %h want %h", udp_txd, PAD);
        else n_pass++;
        do_reset();
    endtask

    task automatic test_basic();
        push(8'h01, 8);
        dat_tx_len = 12'd8;
        fs         = 1'b1;
        @(negedge clk);
        n_total++;
        if (flag_udp_tx_req !== 1'b1) $display("FAIL basic_req: got %b want 1", flag_udp_tx_req);
        else n_pass++;
        repeat (2) @(negedge clk);
        flag_udp_tx_prep = 1'b1;
        @(negedge clk);
        flag_udp_tx_prep = 1'b0;
        @(negedge clk);
        n_total++;
        if ({fs_udp_tx, flag_udp_tx_req} !== 2'b10)
            $display("FAIL basic_start: fs_udp_tx,req got %b want 10", {fs_udp_tx, flag_udp_tx_req});
        else n_pass++;
        n_total++;
        if (udp_tx_len !== 16'h0008) $display("FAIL basic_tx_len: got %h want 0008", udp_tx_len);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            udp_txen = 1'b1;
            if (i == 0) begin
                #1;
                n_total++;
                if (fifo_rxen !== 1'b1) $display("FAIL basic_rxen: got %b want 1", fifo_rxen);
                else n_pass++;
            end
            @(negedge clk);
            n_total++;
            if (udp_txd !== 8'(i + 1)) $display("FAIL basic_txd[%0d]: got %h want %h", i, udp_txd, 8'(i + 1));
            else n_pass++;
        end
        udp_txen  = 1'b0;
        fd_udp_tx = 1'b1;
        @(negedge clk);
        fd_udp_tx = 1'b0;
        n_total++;
        if ({fs_udp_tx, udp_txd} !== {1'b0, PAD})
            $display("FAIL basic_end: fs_udp_tx,txd got %b,%h want 0,%h", fs_udp_tx, udp_txd, PAD);
        else n_pass++;
        wait_fd(10);
        n_total++;
        if ({fd, err} !== 2'b10) $display("FAIL basic_done: fd,err got %b want 10", {fd, err});
        else n_pass++;
        fs = 1'b0;
        @(negedge clk);
        n_total++;
        if (fd !== 1'b0) $display("FAIL basic_fd_clear: got %b want 0", fd);
        else n_pass++;
    endtask

    task automatic test_zero_len();
        dat_tx_len = 12'd0;
        fs         = 1'b1;
        @(negedge clk);
        n_total++;
        if ({flag_udp_tx_req, fd} !== 2'b00) $display("FAIL zero_first: req,fd got %b want 00", {flag_udp_tx_req, fd});
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({flag_udp_tx_req, fd} !== 2'b01) $display("FAIL zero_fd: req,fd got %b want 01", {flag_udp_tx_req, fd});
        else n_pass++;
        fs = 1'b0;
        @(negedge clk);
        n_total++;
        if (fd !== 1'b0) $display("FAIL zero_fd_clear: got %b want 0", fd);
        else n_pass++;
    endtask

    task automatic test_clamp();
        dat_tx_len       = 12'hFFF;
        fs               = 1'b1;
        flag_udp_tx_prep = 1'b1;
        @(negedge clk);
        n_total++;
        if (err !== 1'b1) $display("FAIL clamp_err: got %b want 1", err);
        else n_pass++;
        repeat (2) @(negedge clk);
        n_total++;
        if (udp_tx_len !== 16'd1472) $display("FAIL clamp_len: got %0d want 1472", udp_tx_len);
        else n_pass++;
        do_reset();
    endtask

    task automatic test_underrun();
        int r0;
        n_total++;
        if (err !== 1'b0) $display("FAIL underrun_err_pre: got %b want 0", err);
        else n_pass++;
        push(8'h01, 3);
        start_frame(12'd6);
        for (int i = 0; i < 6; i++) begin
            udp_txen = 1'b1;
            @(negedge clk);
            n_total++;
            if (udp_txd !== ((i < 3) ? 8'(i + 1) : PAD))
                $display("FAIL underrun_txd[%0d]: got %h want %h", i, udp_txd, (i < 3) ? 8'(i + 1) : PAD);
            else n_pass++;
        end
        udp_txen = 1'b0;
        n_total++;
        if (err !== 1'b1) $display("FAIL underrun_err: got %b want 1", err);
        else n_pass++;
        fd_udp_tx = 1'b1;
        @(negedge clk);
        fd_udp_tx = 1'b0;
        repeat (4) @(negedge clk);
        n_total++;
        if ({fd, fifo_rxen} !== 2'b00) $display("FAIL underrun_stall: fd,rxen got %b want 00", {fd, fifo_rxen});
        else n_pass++;
        r0 = rxen_cnt;
        push(8'h11, 3);
        wait_fd(10);
        n_total++;
        if (fd !== 1'b1) $display("FAIL underrun_done: got %b want 1", fd);
        else n_pass++;
        n_total++;
        if (rxen_cnt - r0 !== 3) $display("FAIL underrun_drain_reads: got %0d want 3", rxen_cnt - r0);
        else n_pass++;
        fs = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_early_done();
        int r0;
        push(8'h20, 10);
        start_frame(12'd10);
        for (int i = 0; i < 4; i++) begin
            udp_txen = 1'b1;
            @(negedge clk);
            n_total++;
            if (udp_txd !== 8'h20 + 8'(i)) $display("FAIL early_txd[%0d]: got %h want %h", i, udp_txd, 8'h20 + 8'(i));
            else n_pass++;
        end
        udp_txen  = 1'b0;
        r0        = rxen_cnt;
        fd_udp_tx = 1'b1;
        @(negedge clk);
        fd_udp_tx = 1'b0;
        n_total++;
        if (fs_udp_tx !== 1'b0) $display("FAIL early_fs_tx: got %b want 0", fs_udp_tx);
        else n_pass++;
        wait_fd(20);
        n_total++;
        if ({fd, fifo_empty} !== 2'b11) $display("FAIL early_done: fd,empty got %b want 11", {fd, fifo_empty});
        else n_pass++;
        n_total++;
        if (rxen_cnt - r0 !== 6) $display("FAIL early_drain_reads: got %0d want 6", rxen_cnt - r0);
        else n_pass++;
        fs = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int n_req = 0;
        do_reset();
        n_total++;
        if (err !== 1'b0) $display("FAIL timeout_err_pre: got %b want 0", err);
        else n_pass++;
        push(8'h40, 5);
        dat_tx_len = 12'd5;
        fs         = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            if (!flag_udp_tx_req) break;
            n_req++;
            @(negedge clk);
        end
        n_total++;
        if (n_req !== 16) $display("FAIL timeout_req_cycles: got %0d want 16", n_req);
        else n_pass++;
        n_total++;
        if ({err, fs_udp_tx} !== 2'b10) $display("FAIL timeout_err: err,fs_tx got %b want 10", {err, fs_udp_tx});
        else n_pass++;
        wait_fd(20);
        n_total++;
        if ({fd, fifo_empty} !== 2'b11) $display("FAIL timeout_done: fd,empty got %b want 11", {fd, fifo_empty});
        else n_pass++;
        fs = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_send();
        push(8'h31, 4);
        start_frame(12'd4);
        n_total++;
        if (fs_udp_tx !== 1'b1) $display("FAIL midrst_send: got %b want 1", fs_udp_tx);
        else n_pass++;
        udp_txen = 1'b1;
        @(negedge clk);
        n_total++;
        if (udp_txd !== 8'h31) $display("FAIL midrst_txd: got %h want 31", udp_txd);
        else n_pass++;
        #1;
        n_total++;
        if (fifo_rxen !== 1'b1) $display("FAIL midrst_rxen: got %b want 1", fifo_rxen);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({fd, fifo_rxen, flag_udp_tx_req, fs_udp_tx, err} !== 5'b0)
            $display("FAIL midrst_flags: got %b want 00000", {fd, fifo_rxen, flag_udp_tx_req, fs_udp_tx, err});
        else n_pass++;
        n_total++;
        if ({udp_tx_len, udp_txd} !== {16'h0000, PAD})
            $display("FAIL midrst_data: len,txd got %h,%h want 0000,%h", udp_tx_len, udp_txd, PAD);
        else n_pass++;
        udp_txen = 1'b0;
        fs       = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst_n            = 1'b0;
        fs               = 1'b0;
        dat_tx_len       = '0;
        flag_udp_tx_prep = 1'b0;
        fd_udp_tx        = 1'b0;
        udp_txen         = 1'b0;
        test_reset();
        test_basic();
        test_zero_len();
        test_clamp();
        test_underrun();
        test_early_done();
        test_timeout();
        test_reset_mid_send();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
